// File: rtl/key_striker.sv
// Timed solenoid driver: turns note requests into fixed-width strike pulses while
// enforcing a per-key rest time and a cap on simultaneously energised keys.
module key_striker #(
  parameter int STRIKE_CYCLES = 50000,
  parameter int REST_CYCLES   = 100000,
  parameter int MAX_ACTIVE    = 4,
  parameter int CNT_W         = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        note_strobe,
  input  logic [11:0] note_word,
  output logic [3:0]  gpioBank1,
  output logic [3:0]  gpioBank2,
  output logic [3:0]  gpioBank3,
  output logic        busy,
  output logic [3:0]  active_count
);

  typedef enum logic [1:0] {S_IDLE, S_STRIKE, S_REST} state_e;

  localparam logic [CNT_W-1:0] STRIKE_LD = CNT_W'(STRIKE_CYCLES);
  localparam logic [CNT_W-1:0] REST_LD   = CNT_W'(REST_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);
  localparam logic [3:0]       MAX_ACT   = 4'(MAX_ACTIVE);

  state_e           state_q [12];
  state_e           state_d [12];
  logic [CNT_W-1:0] cnt_q   [12];
  logic [CNT_W-1:0] cnt_d   [12];
  logic [11:0]      pend_q, pend_d;
  logic [11:0]      elig, grant, strike_v, busy_v;
  logic [3:0]       act;
  logic             found;

  // Status is derived from registered state only, so reset clears it immediately.
  always_comb begin
    act      = '0;
    strike_v = '0;
    busy_v   = '0;
    elig     = '0;
    for (int i = 0; i < 12; i++) begin
      strike_v[i] = (state_q[i] == S_STRIKE);
      busy_v[i]   = pend_q[i] || (state_q[i] != S_IDLE);
      elig[i]     = pend_q[i] && ((state_q[i] == S_IDLE) ||
                                  ((state_q[i] == S_REST) && (cnt_q[i] == CNT_LAST)));
      act         = act + {3'b000, strike_v[i]};
    end
  end

  // One launch per edge, lowest eligible index first, only while below the supply cap.
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (act < MAX_ACT) begin
      for (int i = 0; i < 12; i++) begin
        if (elig[i] && !found) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pend_d = (pend_q & ~grant) | (note_strobe ? note_word : 12'h000);
    for (int i = 0; i < 12; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (grant[i]) begin
        state_d[i] = S_STRIKE;
        cnt_d[i]   = STRIKE_LD;
      end else begin
        case (state_q[i])
          S_STRIKE: begin
            if (cnt_q[i] == CNT_LAST) begin
              state_d[i] = S_REST;
              cnt_d[i]   = REST_LD;
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_LAST;
            end
          end
          S_REST: begin
            if (cnt_q[i] == CNT_LAST) begin
              state_d[i] = S_IDLE;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_LAST;
            end
          end
          default: begin
            state_d[i] = S_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      for (int i = 0; i < 12; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      pend_q <= pend_d;
      for (int i = 0; i < 12; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign gpioBank1    = strike_v[3:0];
  assign gpioBank2    = strike_v[7:4];
  assign gpioBank3    = strike_v[11:8];
  assign busy         = |busy_v;
  assign active_count = act;

endmodule

// File: tb/tb_key_striker.sv
// Directed bench for key_striker: expected per-cycle output traces are built from
// pulse start times, queued, and compared cycle by cycle against the outputs.
module tb_key_striker;
  localparam int SC = 4;
  localparam int RC = 3;
  localparam int MA = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        note_strobe;
  logic [11:0] note_word;
  logic [3:0]  gpioBank1, gpioBank2, gpioBank3, active_count;
  logic        busy;

  key_striker #(.STRIKE_CYCLES(SC), .REST_CYCLES(RC), .MAX_ACTIVE(MA), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .note_strobe(note_strobe), .note_word(note_word),
    .gpioBank1(gpioBank1), .gpioBank2(gpioBank2), .gpioBank3(gpioBank3),
    .busy(busy), .active_count(active_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] g;
    logic        b;
    logic [3:0]  c;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          rise [12][2];
  logic [11:0] stim [64];

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 12; i++) begin
      rise[i][0] = -1;
      rise[i][1] = -1;
    end
    for (int k = 0; k < 64; k++) stim[k] = 12'h000;
  endtask

  // Cycle k is the interval after edge Ek, where E0 is the capturing edge.
  task automatic push_plan(input int ncyc);
    exp_t e;
    int   last;
    for (int k = 0; k < ncyc; k++) begin
      e.g  = '0;
      last = -1;
      for (int i = 0; i < 12; i++)
        for (int j = 0; j < 2; j++)
          if (rise[i][j] >= 0) begin
            if (k >= rise[i][j] && k < rise[i][j] + SC) e.g[i] = 1'b1;
            if (rise[i][j] + SC + RC > last) last = rise[i][j] + SC + RC;
          end
      e.b = (k < last);
      e.c = 4'($countones(e.g));
      sb.push_back(e);
    end
  endtask

  task automatic check_cycle(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_queue_empty"}, 12'h001, 12'h000);
    end else begin
      e = sb.pop_front();
      chk({tag, "_gpio"}, {gpioBank3, gpioBank2, gpioBank1}, e.g);
      chk({tag, "_busy"}, {11'b0, busy}, {11'b0, e.b});
      chk({tag, "_count"}, {8'b0, active_count}, {8'b0, e.c});
    end
  endtask

  task automatic run_plain(input string tag, input int ncyc);
    push_plan(ncyc);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      check_cycle(tag);
      note_strobe = (stim[k] != 12'h000);
      note_word   = stim[k];
    end
  endtask

  task automatic run(input string tag, input logic [11:0] w0, input int ncyc);
    @(negedge clk);
    note_strobe = 1'b1;
    note_word   = w0;
    run_plain(tag, ncyc);
  endtask

  initial begin
    reset       = 1'b1;
    note_strobe = 1'b0;
    note_word   = 12'h000;
    #1;
    chk("reset_gpio", {gpioBank3, gpioBank2, gpioBank1}, 12'h000);
    chk("reset_busy", {11'b0, busy}, 12'h000);
    chk("reset_count", {8'b0, active_count}, 12'h000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    clear_plan();
    rise[0][0] = 1;
    run("single", 12'h001, 10);

    clear_plan();
    rise[0][0] = 1; rise[1][0] = 2; rise[2][0] = 6; rise[3][0] = 7;
    run("chord4", 12'h00F, 16);

    clear_plan();
    rise[0][0] = 1; rise[0][1] = 8;
    stim[2] = 12'h001;
    run("restrike", 12'h001, 17);

    clear_plan();
    rise[0][0] = 1;
    run("pre_reset", 12'h001, 3);
    @(posedge clk);
    #2;
    reset       = 1'b1;
    note_strobe = 1'b1;
    note_word   = 12'h001;
    #1;
    chk("async_gpio", {gpioBank3, gpioBank2, gpioBank1}, 12'h000);
    chk("async_busy", {11'b0, busy}, 12'h000);
    chk("async_count", {8'b0, active_count}, 12'h000);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset       = 1'b0;
    note_strobe = 1'b0;
    note_word   = 12'h000;
    clear_plan();
    run_plain("post_reset", 10);

    clear_plan();
    run("zero_word", 12'h000, 5);

    clear_plan();
    rise[0][0] = 1; rise[1][0] = 2; rise[4][0] = 6;
    stim[0] = 12'h010;
    stim[1] = 12'h010;
    run("dup_merge", 12'h003, 16);

    clear_plan();
    for (int j = 0; j < 6; j++) begin
      rise[2*j][0]   = 1 + 5*j;
      rise[2*j+1][0] = 2 + 5*j;
    end
    run("all_keys", 12'hFFF, 37);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
